// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor, one bit per clock LSB first, start/done handshake
// diff = a_in - b_in via a single full-subtractor cell and a borrow flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             bf_q;
  logic             busy_q, done_q, borrow_q, ovf_q;
  logic [WIDTH-1:0] diff_q;

  logic             a_bit, b_bit, d_bit, bo_bit;
  logic [WIDTH-1:0] res_full_d;
  logic             ovf_d;

  // The shift registers present operand bit cnt at position 0; on the last
  // step that is the original MSB, which is what the overflow term needs.
  assign a_bit      = a_q[0];
  assign b_bit      = b_q[0];
  assign d_bit      = a_bit ^ b_bit ^ bf_q;
  assign bo_bit     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bf_q);
  assign res_full_d = {d_bit, res_q};
  assign ovf_d      = (a_bit ^ b_bit) & (d_bit ^ a_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bf_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            cnt_q   <= '0;
            bf_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_full_d[WIDTH-1:1];
          bf_q  <= bo_bit;
          if (cnt_q == CNT_LAST) begin
            diff_q   <= res_full_d;
            borrow_q <= bo_bit;
            ovf_q    <= ovf_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule
